// File: rtl/id_stage_pipe.sv
// id_stage_pipe
//   Instruction-decode stage with an integrated ID/EX pipeline register.
//   Decodes one RV32 instruction per cycle into register operands, a
//   sign-extended immediate and EX/MEM/WB control bundles. It also holds the
//   register file (with optional WB->read bypass), detects load-use hazards
//   against EX, and handles valid/ready back-pressure, flush and a saturating
//   hazard-stall counter.
//
// Ports
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_valid / o_ready     IF -> ID handshake
//   i_instr, i_pc         instruction word and its PC
//   i_flush               kill the ID/EX entry and block capture
//   i_exMemRead, i_exRd   load-in-EX information for hazard detection
//   i_wrSig/i_wrReg/i_wrData  register-file write port from WB
//   o_valid / i_ready     ID -> EX handshake
//   o_pc, o_rdData1, o_rdData2, o_immediate, o_rs1, o_rs2, o_rd  payload
//   o_ctrlEX   {alu_op[1:0], alu_src[1:0], func3[2:0], func7[6:0]}
//              alu_op : 00 add, 01 branch compare, 10 R-type, 11 I-type ALU
//              alu_src: [1] operand A = pc, [0] operand B = immediate
//   o_ctrlMEM  {branch, jump, mem_read, mem_write}
//   o_ctrlWB   {reg_write, mem_to_reg[1:0], is_load, load_func3[2:0]}
//              mem_to_reg: 00 ALU, 01 memory, 10 pc+4, 11 immediate
//   o_stallCnt saturating count of hazard-stall cycles
module id_stage_pipe #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [31:0]              i_instr,
  input  logic [XLEN-1:0]          i_pc,
  input  logic                     i_flush,
  input  logic                     i_exMemRead,
  input  logic [$clog2(NREG)-1:0]  i_exRd,
  input  logic                     i_wrSig,
  input  logic [$clog2(NREG)-1:0]  i_wrReg,
  input  logic [XLEN-1:0]          i_wrData,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [XLEN-1:0]          o_pc,
  output logic [XLEN-1:0]          o_rdData1,
  output logic [XLEN-1:0]          o_rdData2,
  output logic [XLEN-1:0]          o_immediate,
  output logic [$clog2(NREG)-1:0]  o_rs1,
  output logic [$clog2(NREG)-1:0]  o_rs2,
  output logic [$clog2(NREG)-1:0]  o_rd,
  output logic [13:0]              o_ctrlEX,
  output logic [3:0]               o_ctrlMEM,
  output logic [6:0]               o_ctrlWB,
  output logic [31:0]              o_stallCnt
);

  localparam int RW = $clog2(NREG);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  function automatic logic signed [XLEN-1:0] gen_imm(input logic [31:0] ins);
    logic signed [31:0] imm32;
    case (ins[6:0])
      OP_IMM, OP_LOAD, OP_JALR: imm32 = {{20{ins[31]}}, ins[31:20]};
      OP_STORE:                 imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      OP_BRANCH:                imm32 = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         imm32 = {ins[31:12], 12'b0};
      OP_JAL:                   imm32 = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      default:                  imm32 = '0;
    endcase
    // Size cast of a signed value sign-extends to XLEN.
    return XLEN'(imm32);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
    return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
  endfunction

  logic [XLEN-1:0] rf [NREG];

  logic [6:0]               opcode;
  logic [RW-1:0]            rs1_idx, rs2_idx, rd_idx;
  logic [1:0]               alu_op, alu_src;
  logic [3:0]               ctrl_mem;
  logic [6:0]               ctrl_wb;
  logic                     uses_rs1, uses_rs2;
  logic signed [XLEN-1:0]   imm;
  logic [XLEN-1:0]          rd_data1, rd_data2;
  logic                     hazard, accept;

  logic                     vld_p1;
  logic [XLEN-1:0]          pc_p1, rd_data1_p1, rd_data2_p1;
  logic signed [XLEN-1:0]   imm_p1;
  logic [RW-1:0]            rs1_p1, rs2_p1, rd_p1;
  logic [13:0]              ctrl_ex_p1;
  logic [3:0]               ctrl_mem_p1;
  logic [6:0]               ctrl_wb_p1;
  logic [31:0]              stall_cnt_p1;

  // ---- ID stage: decode, register read, hazard ----
  assign opcode  = i_instr[6:0];
  assign rs1_idx = i_instr[15 +: RW];
  assign rs2_idx = i_instr[20 +: RW];
  assign rd_idx  = i_instr[7 +: RW];
  assign imm     = gen_imm(i_instr);

  always_comb begin
    alu_op   = 2'b00;
    alu_src  = 2'b00;
    ctrl_mem = 4'b0000;
    ctrl_wb  = 7'b0000000;
    case (opcode)
      OP_R:      begin alu_op = 2'b10;                   ctrl_wb = 7'b1000000; end
      OP_IMM:    begin alu_op = 2'b11; alu_src = 2'b01;  ctrl_wb = 7'b1000000; end
      OP_LOAD:   begin alu_src = 2'b01; ctrl_mem = 4'b0010;
                       ctrl_wb = {1'b1, 2'b01, 1'b1, i_instr[14:12]}; end
      OP_STORE:  begin alu_src = 2'b01; ctrl_mem = 4'b0001; end
      OP_BRANCH: begin alu_op = 2'b01; ctrl_mem = 4'b1000; end
      OP_JAL:    begin alu_src = 2'b11; ctrl_mem = 4'b0100; ctrl_wb = 7'b1100000; end
      OP_JALR:   begin alu_src = 2'b01; ctrl_mem = 4'b0100; ctrl_wb = 7'b1100000; end
      OP_LUI:    begin alu_src = 2'b01;                  ctrl_wb = 7'b1110000; end
      OP_AUIPC:  begin alu_src = 2'b11;                  ctrl_wb = 7'b1000000; end
      default:   ;
    endcase
  end

  assign uses_rs1 = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
  assign uses_rs2 = (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);

  // Index 0 is hard-wired to zero; the WB bypass only applies to real registers.
  always_comb begin
    rd_data1 = (rs1_idx == '0) ? '0 : rf[rs1_idx];
    rd_data2 = (rs2_idx == '0) ? '0 : rf[rs2_idx];
    if (BYPASS != 0 && i_wrSig && i_wrReg == rs1_idx && rs1_idx != '0) rd_data1 = i_wrData;
    if (BYPASS != 0 && i_wrSig && i_wrReg == rs2_idx && rs2_idx != '0) rd_data2 = i_wrData;
  end

  assign hazard = i_valid && i_exMemRead && (i_exRd != '0) &&
                  ((uses_rs1 && rs1_idx == i_exRd) || (uses_rs2 && rs2_idx == i_exRd));
  assign o_ready = !hazard && !i_flush && (!vld_p1 || i_ready);
  assign accept  = i_valid && o_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (i_wrSig && i_wrReg != '0) begin
      rf[i_wrReg] <= i_wrData;
    end
  end

  // ---- ID/EX register ----
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      vld_p1       <= 1'b0;
      stall_cnt_p1 <= '0;
      pc_p1        <= '0;
      rd_data1_p1  <= '0;
      rd_data2_p1  <= '0;
      imm_p1       <= '0;
      rs1_p1       <= '0;
      rs2_p1       <= '0;
      rd_p1        <= '0;
      ctrl_ex_p1   <= '0;
      ctrl_mem_p1  <= '0;
      ctrl_wb_p1   <= '0;
    end else begin
      if (hazard && !i_flush) stall_cnt_p1 <= sat_inc(stall_cnt_p1);
      if (i_flush) begin
        vld_p1 <= 1'b0;
      end else if (accept) begin
        vld_p1      <= 1'b1;
        pc_p1       <= i_pc;
        rd_data1_p1 <= rd_data1;
        rd_data2_p1 <= rd_data2;
        imm_p1      <= imm;
        rs1_p1      <= rs1_idx;
        rs2_p1      <= rs2_idx;
        rd_p1       <= rd_idx;
        ctrl_ex_p1  <= {alu_op, alu_src, i_instr[14:12], i_instr[31:25]};
        ctrl_mem_p1 <= ctrl_mem;
        ctrl_wb_p1  <= ctrl_wb;
      end else if (!vld_p1 || i_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign o_valid     = vld_p1;
  assign o_pc        = pc_p1;
  assign o_rdData1   = rd_data1_p1;
  assign o_rdData2   = rd_data2_p1;
  assign o_immediate = imm_p1;
  assign o_rs1       = rs1_p1;
  assign o_rs2       = rs2_p1;
  assign o_rd        = rd_p1;
  assign o_ctrlEX    = ctrl_ex_p1;
  assign o_ctrlMEM   = ctrl_mem_p1;
  assign o_ctrlWB    = ctrl_wb_p1;
  assign o_stallCnt  = stall_cnt_p1;

endmodule
